// File: rtl/ne_ldpc_ctrl_pkg.sv
// Shared constants, FSM state type and a width helper for the layered-decoder
// address-generation controller.
//   Z, P      : circulant size and parallel RCU lanes
//   ROWDEPTH  : row addresses per layer, ceil(Z/P)
//   P_LAST    : active lanes on the final row of a layer
package ne_ldpc_ctrl_pkg;

  localparam int unsigned Z        = 511;
  localparam int unsigned P        = 26;
  localparam int unsigned ROWDEPTH = (Z + P - 1) / P;
  localparam int unsigned P_LAST   = Z - P * (ROWDEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bits needed to index n values; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while (((32'd1 << w) < n) && (w < 31)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ne_lane_mask_gen.sv
// Per-lane enable mask for one row read.
//   last_row    : in  1  current row is the final row of the layer
//   lane_mask_c : out P  all ones, or only the low P_LAST lanes on the last row
module ne_lane_mask_gen #(
  parameter int unsigned P      = ne_ldpc_ctrl_pkg::P,
  parameter int unsigned P_LAST = ne_ldpc_ctrl_pkg::P_LAST
) (
  input  logic         last_row,
  output logic [P-1:0] lane_mask_c
);

  localparam logic [P-1:0] LAST_MASK = P'({P{1'b1}} >> (P - P_LAST));

  always_comb begin
    lane_mask_c = '1;
    if (last_row) lane_mask_c = LAST_MASK;
  end

endmodule

// File: rtl/ne_addrgen_ctrl_et.sv
// Address-generation controller for the layered row computer: sequences row
// and layer reads for P lanes, drains the RCU pipeline between layers, and
// stops on an iteration limit or a satisfied syndrome.
//   clk, rst (sync, active-low)
//   start, loaden, et_en, itr_limit, parity_valid, parity_ok : control inputs
//   decoder_ready, firstprocessing_indicate, lyr_index, rowaddress,
//   rd_L, rcu_en, rden_E, itr_count, early_term             : registered outputs
module ne_addrgen_ctrl_et
  import ne_ldpc_ctrl_pkg::*;
#(
  parameter int unsigned Z              = ne_ldpc_ctrl_pkg::Z,
  parameter int unsigned P              = ne_ldpc_ctrl_pkg::P,
  parameter int unsigned LAYERS         = 2,
  parameter int unsigned ROWDEPTH       = ne_ldpc_ctrl_pkg::ROWDEPTH,
  parameter int unsigned ROWWIDTH       = clog2_w(ROWDEPTH),
  parameter int unsigned LYRWIDTH       = clog2_w(LAYERS),
  parameter int unsigned PIPESTAGES     = 13,
  parameter int unsigned PIPECOUNTWIDTH = 4,
  parameter int unsigned MAXITRS        = 10,
  parameter int unsigned ITRWIDTH       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                loaden,
  input  logic                et_en,
  input  logic [ITRWIDTH-1:0] itr_limit,
  input  logic                parity_valid,
  input  logic                parity_ok,
  output logic                decoder_ready,
  output logic                firstprocessing_indicate,
  output logic [LYRWIDTH-1:0] lyr_index,
  output logic [ROWWIDTH-1:0] rowaddress,
  output logic                rd_L,
  output logic [P-1:0]        rcu_en,
  output logic [P-1:0]        rden_E,
  output logic [ITRWIDTH-1:0] itr_count,
  output logic                early_term
);

  localparam int unsigned P_LAST_L = Z - P * (ROWDEPTH - 1);
  localparam logic [ROWWIDTH-1:0]       ROW_LAST  = ROWWIDTH'(ROWDEPTH - 1);
  localparam logic [LYRWIDTH-1:0]       LYR_LAST  = LYRWIDTH'(LAYERS - 1);
  localparam logic [PIPECOUNTWIDTH-1:0] PIPE_LAST = PIPECOUNTWIDTH'(PIPESTAGES - 1);
  localparam logic [ITRWIDTH-1:0]       ITR_MAX   = ITRWIDTH'(MAXITRS);

  state_t                    state_q, state_n;
  logic [ROWWIDTH-1:0]       row_n;
  logic [LYRWIDTH-1:0]       lyr_n;
  logic [PIPECOUNTWIDTH-1:0] pipe_q, pipe_n;
  logic [ITRWIDTH-1:0]       itr_n, limit_q, limit_n, limit_eff_c;
  logic                      et_n, first_n, go_c, limit_hit_c;
  logic [P-1:0]              lane_mask_c, rcu_en_n, rden_e_n;

  // Mask is evaluated for the row that will be presented next cycle.
  ne_lane_mask_gen #(
    .P      (P),
    .P_LAST (P_LAST_L)
  ) u_lane_mask (
    .last_row    (row_n == ROW_LAST),
    .lane_mask_c (lane_mask_c)
  );

  // Start is honoured only when idle or finished and Lmem is not loading.
  assign go_c        = start && !loaden && ((state_q == IDLE) || (state_q == DONE));
  assign limit_eff_c = ((itr_limit == '0) || (itr_limit > ITR_MAX)) ? ITR_MAX : itr_limit;
  assign limit_hit_c = (itr_count == limit_q);

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    row_n   = rowaddress;
    lyr_n   = lyr_index;
    pipe_n  = pipe_q;
    itr_n   = itr_count;
    limit_n = limit_q;
    et_n    = early_term;
    first_n = firstprocessing_indicate;

    unique case (state_q)
      IDLE, DONE: begin
        if (go_c) begin
          state_n = RUN;
          row_n   = '0;
          lyr_n   = '0;
          pipe_n  = '0;
          itr_n   = '0;
          limit_n = limit_eff_c;
          et_n    = 1'b0;
          first_n = 1'b1;
        end
      end
      RUN: begin
        if (rowaddress == ROW_LAST) begin
          state_n = DRAIN;
          pipe_n  = '0;
          first_n = 1'b0;
        end else begin
          row_n = rowaddress + ROWWIDTH'(1);
        end
      end
      DRAIN: begin
        if (pipe_q == PIPE_LAST) begin
          if (lyr_index != LYR_LAST) begin
            state_n = RUN;
            row_n   = '0;
            lyr_n   = lyr_index + LYRWIDTH'(1);
          end else begin
            state_n = CHECK;
            lyr_n   = '0;
            // Saturate so the count never passes the latched limit.
            if (itr_count < limit_q) itr_n = itr_count + ITRWIDTH'(1);
          end
        end else begin
          pipe_n = pipe_q + PIPECOUNTWIDTH'(1);
        end
      end
      CHECK: begin
        if (!et_en || parity_valid) begin
          if (et_en && parity_ok) begin
            state_n = DONE;
            et_n    = 1'b1;
          end else if (limit_hit_c) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            row_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // First-pass E memory holds nothing, so it is only read from iteration 2.
    rcu_en_n = (state_n == RUN) ? lane_mask_c : '0;
    rden_e_n = (itr_n != '0) ? rcu_en_n : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q                  <= IDLE;
      pipe_q                   <= '0;
      limit_q                  <= '0;
      rowaddress               <= '0;
      lyr_index                <= '0;
      itr_count                <= '0;
      early_term               <= 1'b0;
      firstprocessing_indicate <= 1'b0;
      decoder_ready            <= 1'b0;
      rd_L                     <= 1'b0;
      rcu_en                   <= '0;
      rden_E                   <= '0;
    end else begin
      state_q                  <= state_n;
      pipe_q                   <= pipe_n;
      limit_q                  <= limit_n;
      rowaddress               <= row_n;
      lyr_index                <= lyr_n;
      itr_count                <= itr_n;
      early_term               <= et_n;
      firstprocessing_indicate <= first_n;
      decoder_ready            <= (state_n == DONE);
      rd_L                     <= (state_n == RUN);
      rcu_en                   <= rcu_en_n;
      rden_E                   <= rden_e_n;
    end
  end

endmodule

// File: tb/tb_ne_addrgen_ctrl_et.sv
// Directed self-checking bench for ne_addrgen_ctrl_et at default parameters.
// Inputs are driven and outputs sampled on the falling edge; cycle offset c
// counts rising edges after the edge that samples start (c=0).
module tb_ne_addrgen_ctrl_et;

  localparam logic [31:0] FULL = 32'h03FF_FFFF;
  localparam logic [31:0] PART = 32'h0001_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, loaden, et_en, parity_valid, parity_ok;
  logic [3:0]  itr_limit;
  logic        decoder_ready, firstprocessing_indicate, rd_L, early_term;
  logic [0:0]  lyr_index;
  logic [4:0]  rowaddress;
  logic [25:0] rcu_en, rden_E;
  logic [3:0]  itr_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ne_addrgen_ctrl_et dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .loaden                   (loaden),
    .et_en                    (et_en),
    .itr_limit                (itr_limit),
    .parity_valid             (parity_valid),
    .parity_ok                (parity_ok),
    .decoder_ready            (decoder_ready),
    .firstprocessing_indicate (firstprocessing_indicate),
    .lyr_index                (lyr_index),
    .rowaddress               (rowaddress),
    .rd_L                     (rd_L),
    .rcu_en                   (rcu_en),
    .rden_E                   (rden_E),
    .itr_count                (itr_count),
    .early_term               (early_term)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_rdl"},   32'(rd_L), 32'd0);
    check_eq({tag, "_rcu"},   32'(rcu_en), 32'd0);
    check_eq({tag, "_rde"},   32'(rden_E), 32'd0);
    check_eq({tag, "_row"},   32'(rowaddress), 32'd0);
    check_eq({tag, "_lyr"},   32'(lyr_index), 32'd0);
    check_eq({tag, "_itr"},   32'(itr_count), 32'd0);
    check_eq({tag, "_rdy"},   32'(decoder_ready), 32'd0);
    check_eq({tag, "_first"}, 32'(firstprocessing_indicate), 32'd0);
    check_eq({tag, "_et"},    32'(early_term), 32'd0);
  endtask

  // Pulse start, then watch a bounded window; parity_ok rises at c == ok_at.
  task automatic run_decode(input int max_cyc, input int ok_at,
                            output int ready_at, output int rdl_cnt,
                            output logic [31:0] itr0, output logic [31:0] rdy0);
    ready_at = -1;
    rdl_cnt  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    itr0 = 32'(itr_count);
    rdy0 = 32'(decoder_ready);
    if (rd_L) rdl_cnt++;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == ok_at) parity_ok = 1'b1;
      if (rd_L) rdl_cnt++;
      if (decoder_ready && ready_at < 0) ready_at = c;
    end
  endtask

  initial begin
    int          ready_at, rdl_cnt;
    logic [31:0] itr0, rdy0;

    rst = 1'b0; start = 1'b0; loaden = 1'b0; et_en = 1'b0;
    itr_limit = 4'd0; parity_valid = 1'b0; parity_ok = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Start while Lmem is loading is dropped.
    loaden = 1'b1; start = 1'b1;
    @(negedge clk);
    loaden = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("ld_ign_rdl", 32'(rd_L), 32'd0);
    check_eq("ld_ign_rdy", 32'(decoder_ready), 32'd0);

    // Full 10-iteration decode, early termination off, stray start in RUN.
    ready_at = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t1_rdl0",   32'(rd_L), 32'd1);
    check_eq("t1_row0",   32'(rowaddress), 32'd0);
    check_eq("t1_first0", 32'(firstprocessing_indicate), 32'd1);
    check_eq("t1_rcu0",   32'(rcu_en), FULL);
    check_eq("t1_rde0",   32'(rden_E), 32'd0);
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 40) start = 1'b1;
      if (c == 41) start = 1'b0;
      if (decoder_ready && ready_at < 0) ready_at = c;
      if (c == 19) begin
        check_eq("t1_row19",  32'(rowaddress), 32'd19);
        check_eq("t1_rcu19",  32'(rcu_en), PART);
        check_eq("t1_rde19",  32'(rden_E), 32'd0);
      end
      if (c == 20) begin
        check_eq("t1_drn_rdl", 32'(rd_L), 32'd0);
        check_eq("t1_drn_rcu", 32'(rcu_en), 32'd0);
        check_eq("t1_first20", 32'(firstprocessing_indicate), 32'd0);
      end
      if (c == 33) begin
        check_eq("t1_lyr1",     32'(lyr_index), 32'd1);
        check_eq("t1_lyr1_row", 32'(rowaddress), 32'd0);
        check_eq("t1_lyr1_rdl", 32'(rd_L), 32'd1);
      end
      if (c == 52) check_eq("t1_rcu52", 32'(rcu_en), PART);
      if (c == 66) begin
        check_eq("t1_chk_itr", 32'(itr_count), 32'd1);
        check_eq("t1_chk_rdl", 32'(rd_L), 32'd0);
      end
      if (c == 67) begin
        check_eq("t1_it2_lyr", 32'(lyr_index), 32'd0);
        check_eq("t1_it2_rde", 32'(rden_E), FULL);
      end
      if (c == 86) check_eq("t1_it2_rde_last", 32'(rden_E), PART);
      if (c == 669) check_eq("t1_rdy669", 32'(decoder_ready), 32'd0);
    end
    check_eq("t1_ready_at", 32'(ready_at), 32'd670);
    check_eq("t1_itr",      32'(itr_count), 32'd10);
    check_eq("t1_et",       32'(early_term), 32'd0);
    check_eq("t1_rdy_hold", 32'(decoder_ready), 32'd1);
    check_eq("t1_done_rdl", 32'(rd_L), 32'd0);

    // Early termination on the second CHECK; restart from DONE.
    et_en = 1'b1; itr_limit = 4'd5; parity_valid = 1'b1; parity_ok = 1'b0;
    run_decode(300, 70, ready_at, rdl_cnt, itr0, rdy0);
    check_eq("et_restart_itr", itr0, 32'd0);
    check_eq("et_restart_rdy", rdy0, 32'd0);
    check_eq("et_ready_at",    32'(ready_at), 32'd134);
    check_eq("et_rdl_cnt",     32'(rdl_cnt), 32'd80);
    check_eq("et_itr",         32'(itr_count), 32'd2);
    check_eq("et_flag",        32'(early_term), 32'd1);

    // Limit of 3 with parity never satisfied.
    parity_ok = 1'b0; itr_limit = 4'd3;
    run_decode(260, -1, ready_at, rdl_cnt, itr0, rdy0);
    check_eq("lim3_restart_itr", itr0, 32'd0);
    check_eq("lim3_ready_at",    32'(ready_at), 32'd201);
    check_eq("lim3_rdl_cnt",     32'(rdl_cnt), 32'd120);
    check_eq("lim3_itr",         32'(itr_count), 32'd3);
    check_eq("lim3_et",          32'(early_term), 32'd0);

    // Out-of-range limit falls back to the ceiling.
    et_en = 1'b0; parity_valid = 1'b0; itr_limit = 4'd12;
    run_decode(700, -1, ready_at, rdl_cnt, itr0, rdy0);
    check_eq("lim12_ready_at", 32'(ready_at), 32'd670);
    check_eq("lim12_rdl_cnt",  32'(rdl_cnt), 32'd400);
    check_eq("lim12_itr",      32'(itr_count), 32'd10);

    // Reset during the drain of layer 1 aborts cleanly.
    itr_limit = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("rst_pre_lyr", 32'(lyr_index), 32'd1);
    check_eq("rst_pre_rdl", 32'(rd_L), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_mid");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_idle_rdl", 32'(rd_L), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_re_rdl",   32'(rd_L), 32'd1);
    check_eq("rst_re_row",   32'(rowaddress), 32'd0);
    check_eq("rst_re_lyr",   32'(lyr_index), 32'd0);
    check_eq("rst_re_first", 32'(firstprocessing_indicate), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("rst_re_row5",  32'(rowaddress), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
